mips_multicycle_ctrl: RTL and testbench

//  Control FSM for the multicycle MIPS core, replacing the single-cycle combinational control unit.

---
 rtl/mips_mc_pkg.sv | 49 ++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 27 ++
 rtl/mips_multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Holds the state enum plus the opcode, funct and ALU-control constants.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module mips_alu_decoder
  import mips_mc_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 funct_ok
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_control = ALU_ADD;
    funct_ok    = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: funct_ok    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM sharing one memory port with a mem_ready handshake.
// Define MIPS_MC_JUMP_EN to support the j instruction; otherwise j traps.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [1:0]           pc_src,
  output logic                 pc_en,
  output logic                 illegal,
  output logic [3:0]           state_o
);

  state_t state, next_state;

  logic [ALUCTRL_W-1:0] dec_alu_control;
  logic                 dec_funct_ok;
  logic                 mem_write_raw, ir_write_raw, reg_write_raw;
  logic                 pc_write, branch;

  mips_alu_decoder #(
    .FUNCT_W   (FUNCT_W),
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .funct       (funct),
    .alu_control (dec_alu_control),
    .funct_ok    (dec_funct_ok)
  );

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_control   = ALU_ADD;
    pc_src        = PC_ALU;
    pc_write      = 1'b0;
    branch        = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        ir_write_raw = mem_ready;
        pc_write     = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm<<2) so BRANCH only has to compare.
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
`ifdef MIPS_MC_JUMP_EN
          OP_J:         next_state = S_JUMP;
`endif
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWRITE: begin
        iord          = 1'b1;
        mem_write_raw = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = dec_alu_control;
        next_state  = dec_funct_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PC_ALUOUT;
        branch      = 1'b1;
        next_state  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
`ifdef MIPS_MC_JUMP_EN
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
`endif
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_TRAP;
    endcase
  end

  // Strobes are also masked by rst_n so FETCH's mem_ready gating cannot fire during reset.
  assign mem_write = mem_write_raw & rst_n;
  assign ir_write  = ir_write_raw & rst_n;
  assign reg_write = reg_write_raw & rst_n;
  assign pc_en     = (pc_write | (branch & zero)) & rst_n;
  assign illegal   = (state == S_TRAP);
  assign state_o   = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: directed and randomized instruction streams against a path-based reference model.
// Honours MIPS_MC_JUMP_EN the same way as the design.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       pc_en, illegal;
  logic [3:0] state_o;
  logic [15:0] outs;

  int tests  = 0;
  int failed = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .pc_en(pc_en), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign outs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, alu_control, pc_src, pc_en, illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit funct_valid(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Cycle counts with mem_ready always high, straight from the instruction timing table.
  function automatic int lat_of(input logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b001000: return 4;
      default:   return 3;
    endcase
  endfunction

  // Expected output vector for a state number, in the same packing as 'outs'.
  function automatic logic [15:0] expect_outs(input int st, input logic mr, input logic z,
                                              input logic [5:0] fn);
    logic e_iord = 0, e_mw = 0, e_ir = 0, e_rd = 0, e_m2r = 0, e_rw = 0, e_sa = 0;
    logic e_pcen = 0, e_ill = 0;
    logic [1:0] e_sb = 2'b00, e_pcs = 2'b00;
    logic [2:0] e_alu = 3'b010;
    case (st)
      0:  begin e_sb = 2'b01; e_ir = mr; e_pcen = mr; end
      1:  e_sb = 2'b11;
      2:  begin e_sa = 1; e_sb = 2'b10; end
      3:  e_iord = 1;
      4:  begin e_m2r = 1; e_rw = 1; end
      5:  begin e_iord = 1; e_mw = mr; end
      6:  begin e_sa = 1; e_alu = alu_of(fn); end
      7:  begin e_rd = 1; e_rw = 1; end
      8:  begin e_sa = 1; e_alu = 3'b110; e_pcs = 2'b01; e_pcen = z; end
      9:  begin e_sa = 1; e_sb = 2'b10; end
      10: e_rw = 1;
      11: begin e_pcs = 2'b10; e_pcen = 1; end
      default: e_ill = 1;
    endcase
    return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_sb, e_alu, e_pcs, e_pcen, e_ill};
  endfunction

  // Walks the instruction's state path, stalling on memory states while mem_ready is low.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fetch_waits, input int mem_waits, input bit rnd,
                           output bit trapped);
    int path[$];
    int idx = 0, cycles = 0, waits = 0, run = 0, fw = fetch_waits, mw = mem_waits, st;
    bit waitable;
    logic mr;
    path = '{0, 1};
    case (op)
      6'b000000: if (funct_valid(fn)) path = {path, 6, 7}; else path = {path, 6, 12};
      6'b100011: path = {path, 2, 3, 4};
      6'b101011: path = {path, 2, 5};
      6'b000100: path.push_back(8);
      6'b001000: path = {path, 9, 10};
`ifdef MIPS_MC_JUMP_EN
      6'b000010: path.push_back(11);
`endif
      default:   path.push_back(12);
    endcase
    trapped = (path[path.size()-1] == 12);
    while (idx < path.size()) begin
      st = path[idx];
      waitable = (st == 0) || (st == 3) || (st == 5);
      @(negedge clk);
      opcode = op; funct = fn; zero = z;
      if (rnd)             mr = (run < 8) ? ($urandom_range(0, 3) != 0) : 1'b1;
      else if (st == 0)    mr = (fw == 0);
      else if (waitable)   mr = (mw == 0);
      else                 mr = 1'($urandom_range(0, 1));
      mem_ready = mr;
      #1;
      check("state", 32'(state_o), 32'(st));
      check("outs", 32'(outs), 32'(expect_outs(st, mr, z, fn)));
      if (st == 12) break;
      cycles++;
      if (waitable && !mr) begin
        waits++; run++;
        if (st == 0) fw--; else mw--;
      end else begin
        idx++; run = 0;
      end
    end
    if (!trapped) check("latency", 32'(cycles), 32'(lat_of(op) + waits));
  endtask

  task automatic trap_hold();
    repeat (20) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      opcode    = 6'($urandom);
      #1;
      check("trap_state", 32'(state_o), 32'd12);
      check("trap_outs", 32'(outs), 32'(expect_outs(12, 1'b0, 1'b0, 6'd0)));
    end
  endtask

  // Asserts reset mid-cycle and checks the asynchronous response, then releases with mem_ready low.
  task automatic mid_reset();
    @(posedge clk);
    mem_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_strobes", {28'd0, mem_write, reg_write, pc_en, ir_write}, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_outs", 32'(outs), 32'(expect_outs(0, 1'b0, 1'b0, 6'd0)));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  logic [5:0] ops[5]    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000};
  logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit tr;
    bit reached;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    #12;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_outs", 32'(outs), 32'(expect_outs(0, 1'b0, 1'b0, 6'd0)));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_instr(6'b000000, functs[i], 1'b0, 0, 0, 0, tr);
    run_instr(6'b100011, 6'd0, 1'b0, 0, 3, 0, tr);
    run_instr(6'b100011, 6'd0, 1'b0, 2, 1, 0, tr);
    run_instr(6'b101011, 6'd0, 1'b0, 0, 2, 0, tr);
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, 0, tr);
    run_instr(6'b000100, 6'd0, 1'b0, 1, 0, 0, tr);
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0, 0, tr);

    // Drive an sw up to MEMWRITE, then pull reset while mem_write is asserted.
    reached = 1'b0;
    opcode = 6'b101011;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      if (state_o == 4'd5) reached = 1'b1;
    end
    check("reach_memwrite", 32'(reached), 32'd1);
    check("memwrite_on", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("memwrite_drop", 32'(mem_write), 32'd0);
    check("memwrite_rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 4)];
`ifdef MIPS_MC_JUMP_EN
      if ($urandom_range(0, 5) == 0) op = 6'b000010;
`endif
      run_instr(op, functs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 0, 0, 1, tr);
    end

    run_instr(6'b000010, 6'd0, 1'b0, 0, 0, 0, tr);
`ifdef MIPS_MC_JUMP_EN
    check("j_no_trap", 32'(tr), 32'd0);
`else
    check("j_trap", 32'(tr), 32'd1);
    trap_hold();
    mid_reset();
`endif

    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 0, tr);
    trap_hold();
    mid_reset();
    run_instr(6'b000000, 6'b000111, 1'b0, 0, 0, 0, tr);
    trap_hold();
    mid_reset();
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0, 0, tr);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
